sc_rr_crossbar_slave_port: RTL and testbench

//  Slave-side transaction stage directly downstream of the round-robin arbiter atoms.
//  - Consumes the arbiter's one-hot grant vector.
//  - Locks the granted master, registers its request onto the single slave bus and holds it until the slave acks.
//  - Routes the ack/read data back to the owning master.
//  - Returns the slave ack to the arbiter so its grant history advances.
//  - Adds a timeout so a dead slave cannot hang the crossbar.

---
 rtl/sc_rr_crossbar_slave_port_pkg.sv | 30 +++
 rtl/sc_rr_crossbar_slave_port_if.sv | 25 ++
 rtl/sc_rr_crossbar_slave_port_onehot_mux.sv | 30 +++
 rtl/sc_rr_crossbar_slave_port.sv | 165 ++++++++++++++++
 tb/tb_sc_rr_crossbar_slave_port.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_rr_crossbar_slave_port_pkg.sv
// Crossbar slave-port shared types and helpers.
// Used by the slave-port stage and other crossbar stages.
package sc_rr_crossbar_slave_port_pkg;

  localparam int MAX_MS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } sp_state_e;

  function automatic logic is_onehot(
    input logic [MAX_MS-1:0] v
  );
    return (v != '0) &&
           ((v & (v - MAX_MS'(1))) == '0);
  endfunction

  function automatic int unsigned oh2idx(
    input logic [MAX_MS-1:0] v
  );
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_MS; i++)
      if (v[i]) idx = idx | 32'(i);
    return idx;
  endfunction

endpackage

// File: rtl/sc_rr_crossbar_slave_port_if.sv
// Single-slave bus between the crossbar port and its slave.
// master drives the request, slave returns ack and read data.
interface sc_rr_crossbar_slave_port_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          req;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          we;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, addr, wdata, we,
    input  ack, rdata
  );

  modport slave (
    input  req, addr, wdata, we,
    output ack, rdata
  );

endinterface

// File: rtl/sc_rr_crossbar_slave_port_onehot_mux.sv
// N-way one-hot select of packed master addr/wdata/we.
// AND-OR form; a zero select yields all zeros.
module sc_rr_crossbar_slave_port_onehot_mux #(
  parameter int N  = 2,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic [N-1:0]    sel,
  input  logic [N*AW-1:0] addr_in,
  input  logic [N*DW-1:0] wdata_in,
  input  logic [N-1:0]    we_in,
  output logic [AW-1:0]   addr,
  output logic [DW-1:0]   wdata,
  output logic            we
);

  always_comb begin
    addr  = '0;
    wdata = '0;
    we    = 1'b0;
    for (int k = 0; k < N; k++) begin
      addr  = addr |
              (addr_in[k*AW +: AW] & {AW{sel[k]}});
      wdata = wdata |
              (wdata_in[k*DW +: DW] & {DW{sel[k]}});
      we    = we | (we_in[k] & sel[k]);
    end
  end

endmodule

// File: rtl/sc_rr_crossbar_slave_port.sv
// Slave-port stage: locks the granted master, drives the slave bus,
// returns ack/rdata to the owner and the arbiter, with timeout.
module sc_rr_crossbar_slave_port
  import sc_rr_crossbar_slave_port_pkg::*;
#(
  parameter int N_MS   = 2,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int TO_CYC = 255
) (
  input  logic               i_clk,
  input  logic               i_resetb,
  input  logic [N_MS-1:0]    i_ms_en,
  input  logic [N_MS-1:0]    i_ms_req,
  input  logic [N_MS*AW-1:0] i_ms_addr,
  input  logic [N_MS*DW-1:0] i_ms_wdata,
  input  logic [N_MS-1:0]    i_ms_we,
  output logic [N_MS-1:0]    o_ms_ack,
  output logic [N_MS-1:0]    o_ms_err,
  output logic [DW-1:0]      o_ms_rdata,
  sc_rr_crossbar_slave_port_if.master sl,
  output logic               o_arb_ack,
  output logic               o_busy,
  output logic               o_grant_err
);

  localparam int IW = $clog2(N_MS);
  localparam int CW =
    (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TO_CYC > 0) ? TO_CYC - 1 : 0);

  sp_state_e state;
  sp_state_e state_nx;

  logic [MAX_MS-1:0] en_w;
  logic              grant_oh;
  logic              capture;
  logic              multi_hot;
  logic              expire;

  logic [AW-1:0]     mux_addr;
  logic [DW-1:0]     mux_wdata;
  logic              mux_we;

  logic [IW-1:0]     owner;
  logic [N_MS-1:0]   owner_oh;
  logic [CW-1:0]     cnt;
  logic              req_q;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     wdata_q;
  logic              we_q;
  logic [DW-1:0]     rdata_q;
  logic [N_MS-1:0]   ack_q;
  logic [N_MS-1:0]   err_q;
  logic              arb_q;
  logic              gerr_q;

  assign en_w      = MAX_MS'(i_ms_en);
  assign grant_oh  = is_onehot(en_w);
  assign capture   = grant_oh &&
                     |(i_ms_en & i_ms_req);
  assign multi_hot = !grant_oh && (i_ms_en != '0);
  assign expire    = (TO_CYC != 0) &&
                     (cnt == CNT_LAST);
  assign owner_oh  = N_MS'(1) << owner;

  sc_rr_crossbar_slave_port_onehot_mux #(
    .N  (N_MS),
    .AW (AW),
    .DW (DW)
  ) u_mux (
    .sel      (i_ms_en),
    .addr_in  (i_ms_addr),
    .wdata_in (i_ms_wdata),
    .we_in    (i_ms_we),
    .addr     (mux_addr),
    .wdata    (mux_wdata),
    .we       (mux_we)
  );

  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) state <= ST_IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (capture) state_nx = ST_REQ;
      ST_REQ:  if (sl.ack || expire)
                 state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // ack has priority over a timeout on the same cycle
  always_ff @(posedge i_clk or negedge i_resetb) begin
    if (!i_resetb) begin
      owner   <= '0;
      cnt     <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      arb_q   <= 1'b0;
      gerr_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      arb_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (capture) begin
            owner   <= IW'(oh2idx(en_w));
            addr_q  <= mux_addr;
            wdata_q <= mux_wdata;
            we_q    <= mux_we;
            req_q   <= 1'b1;
          end
          if (multi_hot) gerr_q <= 1'b1;
        end
        ST_REQ: begin
          if (sl.ack) begin
            req_q   <= 1'b0;
            rdata_q <= we_q ? '0 : sl.rdata;
            ack_q   <= owner_oh;
            arb_q   <= 1'b1;
            cnt     <= '0;
          end else if (expire) begin
            req_q   <= 1'b0;
            rdata_q <= '0;
            ack_q   <= owner_oh;
            err_q   <= owner_oh;
            arb_q   <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RESP: begin
          rdata_q <= '0;
          cnt     <= '0;
        end
        default: ;
      endcase
    end
  end

  assign sl.req      = req_q;
  assign sl.addr     = addr_q;
  assign sl.wdata    = wdata_q;
  assign sl.we       = we_q;
  assign o_ms_ack    = ack_q;
  assign o_ms_err    = err_q;
  assign o_ms_rdata  = rdata_q;
  assign o_arb_ack   = arb_q;
  assign o_busy      = (state != ST_IDLE);
  assign o_grant_err = gerr_q;

endmodule

// File: tb/tb_sc_rr_crossbar_slave_port.sv
// Randomized scoreboard bench for the crossbar slave-port stage.
// Driver queues expected requests; monitor plays slave and checks.
module tb_sc_rr_crossbar_slave_port;

  localparam int N_MS   = 3;
  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int TO_CYC = 4;

  typedef struct {
    int            owner;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we;
  } req_t;

  typedef struct {
    int            owner;
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  logic clk;
  logic rst_n;
  logic [N_MS-1:0]    ms_en, ms_req, ms_we;
  logic [N_MS-1:0]    ms_ack, ms_err;
  logic [N_MS*AW-1:0] ms_addr;
  logic [N_MS*DW-1:0] ms_wdata;
  logic [DW-1:0]      ms_rdata;
  logic arb_ack, busy, grant_err;
  logic mon_en;

  int checks = 0;
  int errors = 0;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  sc_rr_crossbar_slave_port_if #(.AW(AW), .DW(DW)) sl ();

  sc_rr_crossbar_slave_port #(
    .N_MS(N_MS), .AW(AW), .DW(DW), .TO_CYC(TO_CYC)
  ) dut (
    .i_clk       (clk),
    .i_resetb    (rst_n),
    .i_ms_en     (ms_en),
    .i_ms_req    (ms_req),
    .i_ms_addr   (ms_addr),
    .i_ms_wdata  (ms_wdata),
    .i_ms_we     (ms_we),
    .o_ms_ack    (ms_ack),
    .o_ms_err    (ms_err),
    .o_ms_rdata  (ms_rdata),
    .sl          (sl),
    .o_arb_ack   (arb_ack),
    .o_busy      (busy),
    .o_grant_err (grant_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(
    input string name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endfunction

  task automatic scramble();
    int k;
    k = $urandom_range(0, N_MS);
    ms_en  = (k == N_MS) ? '0 : N_MS'(1) << k;
    ms_req = N_MS'($urandom);
    ms_we  = N_MS'($urandom);
    for (int j = 0; j < N_MS; j++) begin
      ms_addr[j*AW +: AW]  = AW'($urandom);
      ms_wdata[j*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic run_txn();
    req_t e;
    bit   got;
    int   n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      scramble();
      if ($urandom_range(0, 1) == 0) ms_en = '0;
      else ms_req = ms_req & ~ms_en;
      @(negedge clk);
    end
    scramble();
    e.owner = $urandom_range(0, N_MS-1);
    e.addr  = AW'($urandom);
    e.wdata = DW'($urandom);
    e.we    = 1'($urandom);
    ms_en = N_MS'(1) << e.owner;
    ms_req[e.owner] = 1'b1;
    ms_we[e.owner]  = e.we;
    ms_addr[e.owner*AW +: AW]  = e.addr;
    ms_wdata[e.owner*DW +: DW] = e.wdata;
    exp_req_q.push_back(e);
    // held across RESP->IDLE so it is seen in IDLE
    repeat (2) @(negedge clk);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (ms_ack != '0) got = 1;
      else begin
        scramble();
        @(negedge clk);
      end
    end
    chk("txn_done", 64'(got), 64'(1));
  endtask

  initial begin : monitor
    req_t cur;
    rsp_t r;
    int d, len, exp_len;
    bit in_req;
    logic [DW-1:0] rd;
    d = 0; len = 0; exp_len = 0; in_req = 0; rd = '0;
    cur = '{owner: 0, addr: '0, wdata: '0, we: 1'b0};
    sl.ack = 1'b0;
    sl.rdata = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_req = 0;
        sl.ack = 1'b0;
        continue;
      end
      if (sl.req && !in_req) begin
        in_req = 1;
        len = 0;
        chk("req_expected",
            64'(exp_req_q.size() != 0), 64'(1));
        if (exp_req_q.size() != 0) begin
          cur = exp_req_q.pop_front();
          d = $urandom_range(0, TO_CYC + 1);
          rd = DW'($urandom);
          r.owner = cur.owner;
          r.err   = (d >= TO_CYC);
          r.rdata = (r.err || cur.we) ? '0 : rd;
          exp_rsp_q.push_back(r);
        end else begin
          d = TO_CYC;
        end
        exp_len = (d >= TO_CYC) ? TO_CYC : d + 1;
      end
      if (sl.req) begin
        chk("sl_bus",
            64'({sl.addr, sl.wdata, sl.we}),
            64'({cur.addr, cur.wdata, cur.we}));
        sl.ack   = (len == d);
        sl.rdata = (len == d) ? rd : DW'($urandom);
        len++;
      end else begin
        if (in_req) begin
          chk("req_len", 64'(len), 64'(exp_len));
          in_req = 0;
        end
        sl.ack   = ($urandom_range(0, 3) == 0);
        sl.rdata = DW'($urandom);
      end
      if (ms_ack != '0 || ms_err != '0 || arb_ack) begin
        chk("rsp_expected",
            64'(exp_rsp_q.size() != 0), 64'(1));
        if (exp_rsp_q.size() != 0) begin
          r = exp_rsp_q.pop_front();
          chk("ms_ack", 64'(ms_ack),
              64'(N_MS'(1) << r.owner));
          chk("ms_err", 64'(ms_err),
              64'(r.err ? N_MS'(1) << r.owner : '0));
          chk("ms_rdata", 64'(ms_rdata), 64'(r.rdata));
          chk("arb_ack", 64'(arb_ack), 64'(1));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: sim did not finish");
    $fatal(1);
  end

  initial begin : main
    bit got;
    logic seen;
    rst_n = 1'b0;
    mon_en = 1'b0;
    ms_en = '0; ms_req = '0; ms_we = '0;
    ms_addr = '0; ms_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        64'({ms_ack, ms_err, ms_rdata, sl.req,
             sl.addr, sl.wdata, sl.we,
             arb_ack, busy, grant_err}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset",
        64'({sl.req, busy, ms_ack}), 64'(0));

    mon_en = 1'b1;
    for (int t = 0; t < 60; t++) run_txn();
    ms_en = '0;
    ms_req = '0;
    repeat (4) @(negedge clk);
    chk("queues_drained",
        64'(exp_req_q.size() + exp_rsp_q.size()), 64'(0));
    chk("grant_err_clean", 64'(grant_err), 64'(0));
    mon_en = 1'b0;
    @(negedge clk);

    ms_en = 3'b001; ms_req = 3'b001; ms_we = '0;
    got = 0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(negedge clk);
      if (sl.req) got = 1;
    end
    chk("rst_req_seen", 64'(got), 64'(1));
    ms_en = '0; ms_req = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_drop",
        64'({sl.req, busy, ms_ack, arb_ack}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | (ms_ack != '0) | arb_ack | sl.req;
    end
    chk("rst_no_ack", 64'(seen), 64'(0));

    ms_en = 3'b011; ms_req = 3'b111;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | sl.req | busy;
    end
    chk("multihot_no_req", 64'(seen), 64'(0));
    chk("grant_err_set", 64'(grant_err), 64'(1));
    ms_en = '0; ms_req = '0;
    repeat (3) @(negedge clk);
    chk("grant_err_sticky", 64'(grant_err), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("grant_err_reset", 64'(grant_err), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
